// File: rtl/divn_fsm.sv
// Programmable clock divider: a two-state IDLE/RUN FSM with a phase counter, pulse or duty
// output, and reconfiguration that is deferred to the next period boundary while running.
module divn_fsm #(
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_n,
  input  logic             mode_in,
  output logic             y,
  output logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             active,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] N_RESET = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] N_MIN   = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic             mode_act_q, mode_act_d;
  logic [WIDTH-1:0] n_pend_q, n_pend_d;
  logic             mode_pend_q, mode_pend_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;

  logic             running;
  logic             at_end;
  logic             load_ok;

  assign running = (state_q == RUN);
  // Terminal count is decoded from registers only, so tick never follows an input.
  assign at_end  = running && (cnt_q == n_act_q - ONE);
  assign load_ok = load && (div_n >= N_MIN);

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_act_d     = n_act_q;
    mode_act_d  = mode_act_q;
    n_pend_d    = n_pend_q;
    mode_pend_d = mode_pend_q;
    pend_d      = pend_q;
    err_d       = load && !load_ok;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load_ok) begin
          n_act_d    = div_n;
          mode_act_d = mode_in;
        end
        if (en) state_d = RUN;
      end

      RUN: begin
        if (!en || at_end) begin
          // Period boundary (wrap or abort): a load on this edge beats any pending one.
          cnt_d  = '0;
          pend_d = 1'b0;
          if (load_ok) begin
            n_act_d    = div_n;
            mode_act_d = mode_in;
          end else if (pend_q) begin
            n_act_d    = n_pend_q;
            mode_act_d = mode_pend_q;
          end
          if (!en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (load_ok) begin
            n_pend_d    = div_n;
            mode_pend_d = mode_in;
            pend_d      = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_act_q     <= N_RESET;
      mode_act_q  <= 1'b0;
      n_pend_q    <= N_RESET;
      mode_pend_q <= 1'b0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_act_q     <= n_act_d;
      mode_act_q  <= mode_act_d;
      n_pend_q    <= n_pend_d;
      mode_pend_q <= mode_pend_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
    end
  end

  assign tick   = at_end;
  assign y      = mode_act_q ? (running && (cnt_q < (n_act_q >> 1))) : at_end;
  assign cnt    = cnt_q;
  assign active = running;
  assign err    = err_q;

endmodule

// File: tb/tb_divn_fsm.sv
// Self-checking bench for divn_fsm: directed scenarios followed by random traffic, all
// compared every cycle against a period-level behavioural model of the divider.
module tb_divn_fsm;

  localparam int W  = 4;
  localparam int DD = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_n = '0;
  logic         mode_in = 1'b0;
  logic         y, tick, active, err;
  logic [W-1:0] cnt;

  divn_fsm #(.WIDTH(W), .DIV_DEFAULT(DD)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .div_n(div_n), .mode_in(mode_in),
    .y(y), .tick(tick), .cnt(cnt), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Model: whether running, position within the current period, active and queued settings.
  bit m_run;
  int m_phase;
  int m_n;
  bit m_mode;
  bit m_err;
  int pend_n[$];
  bit pend_mode[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_phase = 0;
    m_n     = DD;
    m_mode  = 0;
    m_err   = 0;
    pend_n.delete();
    pend_mode.delete();
  endtask

  task automatic check_outputs(string tag);
    bit e_tick, e_y;
    e_tick = m_run && (m_phase == m_n - 1);
    e_y    = m_mode ? (m_run && (m_phase < m_n / 2)) : e_tick;
    check({tag, ".active"}, 32'(active), 32'(m_run));
    check({tag, ".cnt"},    32'(cnt),    m_run ? 32'(m_phase) : 32'd0);
    check({tag, ".tick"},   32'(tick),   32'(e_tick));
    check({tag, ".y"},      32'(y),      32'(e_y));
    check({tag, ".err"},    32'(err),    32'(m_err));
  endtask

  task automatic model_step(bit e, bit l, int d, bit m);
    bit ok;
    bit boundary;
    ok       = l && (d >= 2);
    m_err    = l && !ok;
    boundary = m_run && (!e || m_phase == m_n - 1);
    if (!m_run) begin
      if (ok) begin m_n = d; m_mode = m; end
      m_run   = e;
      m_phase = 0;
    end else if (boundary) begin
      if (ok) begin
        m_n = d; m_mode = m;
      end else if (pend_n.size() > 0) begin
        m_n = pend_n[0]; m_mode = pend_mode[0];
      end
      pend_n.delete();
      pend_mode.delete();
      m_phase = 0;
      m_run   = e;
    end else begin
      m_phase++;
      if (ok) begin
        pend_n.delete();
        pend_mode.delete();
        pend_n.push_back(d);
        pend_mode.push_back(m);
      end
    end
  endtask

  task automatic cycle(string tag, bit e, bit l, int d, bit m);
    en      = e;
    load    = l;
    div_n   = W'(d);
    mode_in = m;
    @(posedge clk);
    model_step(e, l, d, m);
    #1;
    check_outputs(tag);
    load = 1'b0;
  endtask

  task automatic run_cycles(string tag, int n);
    for (int i = 0; i < n; i++) cycle(tag, 1, 0, 0, 0);
  endtask

  task automatic run_until_phase(string tag, int p);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run && m_phase == p) found = 1;
      else cycle(tag, 1, 0, 0, 0);
    end
    if (!found) begin
      total++;
      fails++;
      $error("FAIL %s.timeout: phase %0d not reached within 40 cycles", tag, p);
    end
  endtask

  // Asserts reset between clock edges and checks that outputs clear without a clock edge.
  task automatic async_reset(string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    en   = 1'b0;
    load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset defaults, then the reset divisor of 3 in pulse mode.
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_outputs("post_release");
    run_cycles("default_n3", 9);

    // Duty mode N=5 configured in IDLE.
    cycle("to_idle", 0, 0, 0, 0);
    cycle("load5_duty", 0, 1, 5, 1);
    run_cycles("duty_n5", 12);

    // Deferred reconfiguration: N=4 running, load 6 at cnt=1.
    cycle("to_idle2", 0, 0, 0, 0);
    cycle("load4", 0, 1, 4, 0);
    run_until_phase("defer_n4", 1);
    cycle("load6_mid", 1, 1, 6, 0);
    run_cycles("defer_n6", 15);

    // Rejected loads while running N=3.
    cycle("to_idle3", 0, 0, 0, 0);
    cycle("load3", 0, 1, 3, 0);
    run_cycles("illegal_run", 2);
    cycle("load1_bad", 1, 1, 1, 0);
    run_cycles("illegal_a", 3);
    cycle("load0_bad", 1, 1, 0, 1);
    run_cycles("illegal_b", 6);

    // Pending configuration applied on the en=0 edge.
    cycle("pend_load5", 1, 1, 5, 1);
    cycle("pend_exit", 0, 0, 0, 0);
    run_cycles("pend_applied", 10);

    // Abort mid-period at cnt=2 of N=7, then async reset at cnt=3.
    cycle("to_idle4", 0, 0, 0, 0);
    cycle("load7", 0, 1, 7, 0);
    run_until_phase("abort_n7", 2);
    cycle("abort", 0, 0, 0, 0);
    run_until_phase("rerun_n7", 3);
    cycle("pend_before_rst", 1, 1, 9, 1);
    async_reset("async_rst");
    run_cycles("after_rst_n3", 7);

    // Widest divisor: counter peaks at 14 and wraps.
    cycle("to_idle5", 0, 0, 0, 0);
    cycle("load15", 0, 1, 15, 0);
    run_cycles("n15", 32);

    // Load coincident with the wrap of N=2.
    cycle("to_idle6", 0, 0, 0, 0);
    cycle("load2", 0, 1, 2, 1);
    run_until_phase("n2", 1);
    cycle("load5_at_wrap", 1, 1, 5, 0);
    run_cycles("after_wrap_n5", 11);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle("rnd", $urandom_range(7) != 0, $urandom_range(3) == 0,
              int'($urandom_range(15)), 1'($urandom_range(1)));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
